// File: rtl/qformat_requant_if.sv
// Valid/ready stream bundle for qformat_requant: accumulator words in, requantized words out.
// master = upstream producer / downstream consumer side, slave = the requantizer.
interface qformat_requant_if #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [ACC_W-1:0]   in_acc;
  logic        [SCALE_W-1:0] scale;
  logic        [SHIFT_W-1:0] shift;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_value;
  logic                      out_sat;

  modport master (
    output in_valid, in_acc, scale, shift, out_ready,
    input  in_ready, out_valid, out_value, out_sat
  );

  modport slave (
    input  in_valid, in_acc, scale, shift, out_ready,
    output in_ready, out_valid, out_value, out_sat
  );
endinterface

// File: rtl/qformat_requant.sv
// Two-stage requantizer: scale multiply, then round/shift/saturate to OUT_W-bit signed Q-format.
// Define QFORMAT_ROUND_EN for round-half-up; otherwise the shift truncates toward -inf.
module qformat_requant #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  qformat_requant_if.slave      bus,
  input  logic                  clear_count,
  output logic [15:0]           sat_count
);
  localparam int PW = ACC_W + SCALE_W + 1;
  localparam int RW = PW + 1;
  localparam logic [SHIFT_W-1:0]    SH_MAX = SHIFT_W'(PW - 1);
  localparam logic signed [RW-1:0]  QMAX   = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]  QMIN   = ~QMAX;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s > SH_MAX) ? SH_MAX : s;
  endfunction

`ifdef QFORMAT_ROUND_EN
  // Widened by one bit so adding 2^(sh-1) to the largest product cannot wrap.
  function automatic logic signed [RW-1:0] round_add(input logic signed [PW-1:0] p,
                                                     input logic [SHIFT_W-1:0]   sh);
    logic [RW-1:0] term;
    term = '0;
    if (sh != '0) term = {{(RW-1){1'b0}}, 1'b1} << (sh - SHIFT_W'(1));
    return {p[PW-1], p} + term;
  endfunction
`endif

  // Returns {clamped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] q);
    if (q > QMAX)      return {1'b1, QMAX[OUT_W-1:0]};
    else if (q < QMIN) return {1'b1, QMIN[OUT_W-1:0]};
    else               return {1'b0, q[OUT_W-1:0]};
  endfunction

  logic                      adv1, adv2;
  logic signed [PW-1:0]      prod_p0;
  logic                      vld_p1;
  logic signed [PW-1:0]      prod_p1;
  logic        [SHIFT_W-1:0] shift_p1;
  logic signed [RW-1:0]      rnd_p1;
  logic signed [RW-1:0]      q_p1;
  logic        [OUT_W:0]     sat_p1;

  always_comb begin
    adv2        = !bus.out_valid || bus.out_ready;
    adv1        = !vld_p1 || adv2;
    bus.in_ready = adv1;
    prod_p0     = PW'(bus.in_acc) * PW'($signed({1'b0, bus.scale}));
  end

  // ---- stage 1: product and clamped shift amount ----
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      prod_p1  <= prod_p0;
      shift_p1 <= clamp_shift(bus.shift);
    end
  end

  always_comb begin
`ifdef QFORMAT_ROUND_EN
    rnd_p1 = round_add(prod_p1, shift_p1);
`else
    rnd_p1 = {prod_p1[PW-1], prod_p1};
`endif
    q_p1   = rnd_p1 >>> shift_p1;
    sat_p1 = saturate(q_p1);
  end

  // ---- stage 2: registered output and saturation counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_value <= '0;
      bus.out_sat   <= 1'b0;
      sat_count     <= '0;
    end else begin
      if (adv1) vld_p1 <= bus.in_valid;
      if (adv2) begin
        bus.out_valid <= vld_p1;
        if (vld_p1) begin
          bus.out_value <= sat_p1[OUT_W-1:0];
          bus.out_sat   <= sat_p1[OUT_W];
        end
      end
      if (clear_count)
        sat_count <= '0;
      else if (bus.out_valid && bus.out_ready && bus.out_sat && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
    end
  end
endmodule
